// File: rtl/msrv32_fetch_ctrl_if.sv
// msrv32 fetch controller bus bundle.
// Bus handshake, redirect requests and PC outputs.
interface msrv32_fetch_ctrl_if;
  logic        ahb_ready_in;
  logic        trap_taken_in;
  logic        mret_in;
  logic        branch_taken_in;
  logic        misaligned_instr_in;
  logic [31:0] pc_mux_in;
  logic [1:0]  pc_src_out;
  logic [31:0] pc_out;
  logic        fetch_req_out;
  logic        flush_out;
  logic        misaligned_exc_out;

  modport master (
    input  ahb_ready_in,
    input  trap_taken_in,
    input  mret_in,
    input  branch_taken_in,
    input  misaligned_instr_in,
    input  pc_mux_in,
    output pc_src_out,
    output pc_out,
    output fetch_req_out,
    output flush_out,
    output misaligned_exc_out
  );

  modport slave (
    output ahb_ready_in,
    output trap_taken_in,
    output mret_in,
    output branch_taken_in,
    output misaligned_instr_in,
    output pc_mux_in,
    input  pc_src_out,
    input  pc_out,
    input  fetch_req_out,
    input  flush_out,
    input  misaligned_exc_out
  );
endinterface

// File: rtl/msrv32_fetch_ctrl.sv
// msrv32 fetch controller: PC register, PC mux select,
// stall handling with sticky trap/mret requests.
module msrv32_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input logic               clk_in,
  input logic               rst_n_in,
  msrv32_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        flush_q, flush_d;
  logic        exc_q, exc_d;
  logic        tpend_q, tpend_d;
  logic        mpend_q, mpend_d;
  logic [1:0]  src;
  logic        rdy;
  logic        trap;
  logic        mret;

  assign rdy  = bus.ahb_ready_in;
  assign trap = bus.trap_taken_in;
  assign mret = bus.mret_in;

  // PC mux select; pending requests only count on stall release
  always_comb begin
    src = 2'b11;
    unique case (state_q)
      BOOT: src = 2'b00;
      RUN: begin
        if (rdy && trap)      src = 2'b10;
        else if (rdy && mret) src = 2'b01;
        else                  src = 2'b11;
      end
      STALL: begin
        if (rdy && (trap || tpend_q))      src = 2'b10;
        else if (rdy && (mret || mpend_q)) src = 2'b01;
        else                               src = 2'b11;
      end
      default: src = 2'b00;
    endcase
  end

  // next-state, PC load, flush and misaligned pulse
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = 1'b1;
    flush_d = 1'b0;
    exc_d   = 1'b0;
    tpend_d = tpend_q;
    mpend_d = mpend_q;
    if (state_q == BOOT) begin
      state_d = RUN;
      pc_d    = bus.pc_mux_in;
      flush_d = bus.branch_taken_in;
    end else if (rdy) begin
      state_d = RUN;
      tpend_d = 1'b0;
      mpend_d = 1'b0;
      if (src == 2'b11 && bus.misaligned_instr_in) begin
        exc_d = 1'b1;
      end else begin
        pc_d    = bus.pc_mux_in;
        flush_d = (src != 2'b11) || bus.branch_taken_in;
      end
    end else begin
      state_d = STALL;
      tpend_d = tpend_q || trap;
      mpend_d = mpend_q || (mret && !trap);
    end
  end

  // state and registered outputs, synchronous reset
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= BOOT;
      pc_q    <= BOOT_ADDRESS;
      req_q   <= 1'b0;
      flush_q <= 1'b1;
      exc_q   <= 1'b0;
      tpend_q <= 1'b0;
      mpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      flush_q <= flush_d;
      exc_q   <= exc_d;
      tpend_q <= tpend_d;
      mpend_q <= mpend_d;
    end
  end

  assign bus.pc_src_out         = src;
  assign bus.pc_out             = pc_q;
  assign bus.fetch_req_out      = req_q;
  assign bus.flush_out          = flush_q;
  assign bus.misaligned_exc_out = exc_q;

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Bench for msrv32_fetch_ctrl.
// Scoreboard of expected registered outputs per cycle.
module tb_msrv32_fetch_ctrl;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] EPC  = 32'h0000_0100;
  localparam logic [31:0] TVEC = 32'h0000_0200;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        exc;
    logic        req;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] br_tgt;
  int          checks;
  int          fails;
  exp_t        sb[$];

  msrv32_fetch_ctrl_if bus ();

  msrv32_fetch_ctrl #(
    .BOOT_ADDRESS(BOOT)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external PC mux driven from the select
  always_comb begin
    bus.pc_mux_in = BOOT;
    unique case (bus.pc_src_out)
      2'b00: bus.pc_mux_in = BOOT;
      2'b01: bus.pc_mux_in = EPC;
      2'b10: bus.pc_mux_in = TVEC;
      default:
        bus.pc_mux_in = bus.branch_taken_in ?
                        br_tgt : bus.pc_out + 32'd4;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag,
                     input logic r, rdy, trap, mret,
                     input logic br, mis,
                     input logic [1:0] xsrc,
                     input logic [31:0] xpc,
                     input logic xfl, xexc, xreq);
    exp_t e;
    exp_t got;
    rst_n                   = r;
    bus.ahb_ready_in        = rdy;
    bus.trap_taken_in       = trap;
    bus.mret_in             = mret;
    bus.branch_taken_in     = br;
    bus.misaligned_instr_in = mis;
    #1;
    if (r) chk({tag, ".src"}, 32'(bus.pc_src_out), 32'(xsrc));
    e.tag = tag; e.pc = xpc; e.flush = xfl;
    e.exc = xexc; e.req = xreq;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".pc"}, bus.pc_out, got.pc);
    chk({got.tag, ".flush"}, 32'(bus.flush_out), 32'(got.flush));
    chk({got.tag, ".exc"}, 32'(bus.misaligned_exc_out), 32'(got.exc));
    chk({got.tag, ".req"}, 32'(bus.fetch_req_out), 32'(got.req));
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    br_tgt = 32'h0000_0020;
    rst_n  = 1'b0;
    bus.ahb_ready_in        = 1'b1;
    bus.trap_taken_in       = 1'b0;
    bus.mret_in             = 1'b0;
    bus.branch_taken_in     = 1'b0;
    bus.misaligned_instr_in = 1'b0;
    @(posedge clk);
    #1;
    // reset state
    cyc("rst", 0,1,0,0,0,0, 2'b00, BOOT, 1,0,0);
    chk("rst.src", 32'(bus.pc_src_out), 32'd0);
    // boot and sequential run
    cyc("boot", 1,1,0,0,0,0, 2'b00, 32'h0, 0,0,1);
    cyc("run4", 1,1,0,0,0,0, 2'b11, 32'h4, 0,0,1);
    cyc("run8", 1,1,0,0,0,0, 2'b11, 32'h8, 0,0,1);
    cyc("runc", 1,1,0,0,0,0, 2'b11, 32'hc, 0,0,1);
    cyc("run10", 1,1,0,0,0,0, 2'b11, 32'h10, 0,0,1);
    // plain stall
    for (int i = 0; i < 3; i++)
      cyc("stall", 1,0,0,0,0,0, 2'b11, 32'h10, 0,0,1);
    cyc("unstall", 1,1,0,0,0,0, 2'b11, 32'h14, 0,0,1);
    // trap pulse during stall
    cyc("ts1", 1,0,0,0,0,0, 2'b11, 32'h14, 0,0,1);
    cyc("ts2", 1,0,1,0,0,0, 2'b11, 32'h14, 0,0,1);
    cyc("ts3", 1,0,0,0,0,0, 2'b11, 32'h14, 0,0,1);
    cyc("trel", 1,1,0,0,0,0, 2'b10, TVEC, 1,0,1);
    cyc("tpost", 1,1,0,0,0,0, 2'b11, TVEC + 4, 0,0,1);
    // trap and mret together
    cyc("both", 1,1,1,1,0,0, 2'b10, TVEC, 1,0,1);
    cyc("bpost", 1,1,0,0,0,0, 2'b11, TVEC + 4, 0,0,1);
    cyc("mret", 1,1,0,1,0,0, 2'b01, EPC, 1,0,1);
    cyc("mpost", 1,1,0,0,0,0, 2'b11, EPC + 4, 0,0,1);
    // branch then misaligned branch
    cyc("br", 1,1,0,0,1,0, 2'b11, 32'h20, 1,0,1);
    cyc("mis", 1,1,0,0,1,1, 2'b11, 32'h20, 0,1,1);
    cyc("mistrap", 1,1,1,0,0,1, 2'b10, TVEC, 1,0,1);
    cyc("mismret", 1,1,0,1,0,1, 2'b01, EPC, 1,0,1);
    cyc("m104", 1,1,0,0,0,0, 2'b11, EPC + 4, 0,0,1);
    // pending trap beats pending mret
    cyc("pm", 1,0,0,1,0,0, 2'b11, EPC + 4, 0,0,1);
    cyc("pt", 1,0,1,0,0,0, 2'b11, EPC + 4, 0,0,1);
    cyc("prel", 1,1,0,0,0,0, 2'b10, TVEC, 1,0,1);
    cyc("pclr", 1,1,0,0,0,0, 2'b11, TVEC + 4, 0,0,1);
    // reset in stall drops pending mret
    cyc("sm1", 1,0,0,1,0,0, 2'b11, TVEC + 4, 0,0,1);
    cyc("sm2", 1,0,0,0,0,0, 2'b11, TVEC + 4, 0,0,1);
    cyc("srst", 0,1,0,0,0,0, 2'b00, BOOT, 1,0,0);
    cyc("sboot", 1,1,0,0,0,0, 2'b00, BOOT, 0,0,1);
    cyc("snoepc", 1,1,0,0,0,0, 2'b11, BOOT + 4, 0,0,1);
    // wrap modulo 2^32
    br_tgt = 32'hffff_fffc;
    cyc("wbr", 1,1,0,0,1,0, 2'b11, 32'hffff_fffc, 1,0,1);
    cyc("wrap", 1,1,0,0,0,0, 2'b11, 32'h0, 0,0,1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
